lbm_collide_sequencer: RTL and testbench
========================================

Name: lbm_collide_sequencer

Overview:
- Frame-level controller for the combinational LBM collider.
- On a start pulse it walks every lattice cell in linear order: reads the 9 populations from the distribution memory, presents them and omega to the collider, waits a fixed settle time, captures the collider outputs and writes them back to the same address.
- Sits between the host/AXI control registers and the distribution-function memory. It is the only master driving the collider inputs.

Parameters:
- NX, 64, lattice width in cells
- NY, 32, lattice height in cells
- ADDR_W, 11, cell address width; must satisfy 2^ADDR_W >= NX*NY
- RD_LAT, 1, memory read latency in cycles (>=1)
- COL_LAT, 1, collider settle cycles before capture (>=1)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle frame start request; honoured only in IDLE
- omega_in  in  16  relaxation factor, Q3.13, sampled on accepted start
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse after the last cell's write is accepted
- cell_idx  out  ADDR_W  index of the cell in flight
- mem_rd_en  out  1  read strobe
- mem_rd_addr  out  ADDR_W  read address
- mem_rd_data  in  144  9x16 populations; bits [15:0]=null, then n, ne, e, se, s, sw, w, nw
- mem_wr_en  out  1  write request; held until accepted
- mem_wr_ready  in  1  memory accepts the write when mem_wr_en && mem_wr_ready
- mem_wr_addr  out  ADDR_W  write address
- mem_wr_data  out  144  post-collision populations, same lane order
- col_omega  out  16  latched omega to the collider
- col_f_in  out  144  registered collider inputs
- col_f_out  in  144  collider outputs, same lane order

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; busy, done, mem_rd_en and mem_wr_en all 0.
  - cell_idx, addresses, col_omega, col_f_in and mem_wr_data all 0.
  - Reset mid-frame aborts immediately. No partial write completes after rst_n falls.
- Omega handling: latched into col_omega on an accepted start and held constant for the whole frame. omega_in changes while busy are ignored.
- start while busy is ignored; no queueing.
- FSM states: IDLE, READ, WAIT, COLL, WRITE.
  - IDLE: on start, go to READ; busy=1; cell_idx=0.
  - READ: one cycle; mem_rd_en=1, mem_rd_addr=cell_idx. Then go to WAIT.
  - WAIT: RD_LAT cycles. At the end of the last cycle, mem_rd_data is registered into col_f_in. Then go to COLL.
  - COLL: COL_LAT cycles. At the end of the last cycle, col_f_out is registered into mem_wr_data. Then go to WRITE.
  - WRITE: mem_wr_en=1, mem_wr_addr=cell_idx. Stall while mem_wr_ready=0.
    - On handshake, if cell_idx==NX*NY-1: go to IDLE, pulse done the next cycle, drop busy with done, and wrap cell_idx to 0.
    - Otherwise increment cell_idx and go to READ.
- Throughput: 2+RD_LAT+COL_LAT cycles per cell with mem_wr_ready=1. Frame time is NX*NY times that.
- Data handling: no arithmetic on populations; the block passes them bit-exact. col_f_in is stable from WAIT exit through WRITE.
- Combinational paths: none from inputs to mem_* outputs; all outputs are registered.

Optional Feature:
- Macro LBM_MASS_CHECK_EN.
- When defined:
  - Adds input col_rho[15:0] (Q3.13) and output mass_sum[31:0] (signed).
  - mass_sum clears on accepted start.
  - mass_sum accumulates sign-extended col_rho at each COLL capture.
  - mass_sum is held stable from done until the next start and wraps modulo 2^32.
- When undefined: the ports, accumulator and logic are absent.

Decomposition:
- Package lbm_pkg:
  - Q=9, DW=16, FRAC=13.
  - Lane index constants DIR_NULL..DIR_NW (0..8).
  - Q3.13 ONE=16'h2000.
  - Sequencer state enum.
- One natural sub-module: lbm_cell_counter, a wrapping 0..NX*NY-1 counter with inc, clear and last outputs.

Test Plan:
- NX=4, NY=2, RD_LAT=1, COL_LAT=1, mem_wr_ready=1, start once → 8 writes to addresses 0..7, done exactly 32 cycles after start, busy high for exactly those cycles.
- Memory preloaded with lane k of cell c = c*16+k; collider model = identity → memory unchanged. Collider model = +1 per lane → every word incremented by 1.
- omega_in=16'h2000 at start, changed to 16'h1000 mid-frame → col_omega remains 16'h2000 all frame.
- mem_wr_ready held 0 for 5 cycles on cell 3 → mem_wr_en, mem_wr_addr=3 and mem_wr_data stable throughout; frame done delayed by exactly 5 cycles.
- start pulsed during busy, and rst_n asserted at cell 5 → second start ignored; after reset all outputs 0 and no write to cell 5. A new start restarts at cell 0.
- With LBM_MASS_CHECK_EN and col_rho=16'h2000 per cell over 8 cells → mass_sum=32'h0001_0000 at done.

Source files
------------

// File: rtl/lbm_pkg.sv
// Shared types and constants for the LBM collide datapath (D2Q9, Q3.13 populations).
package lbm_pkg;

   localparam int Q    = 9;
   localparam int DW   = 16;
   localparam int FRAC = 13;

   localparam int DIR_NULL = 0;
   localparam int DIR_N    = 1;
   localparam int DIR_NE   = 2;
   localparam int DIR_E    = 3;
   localparam int DIR_SE   = 4;
   localparam int DIR_S    = 5;
   localparam int DIR_SW   = 6;
   localparam int DIR_W    = 7;
   localparam int DIR_NW   = 8;

   localparam logic [DW-1:0] ONE = 16'h2000;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_READ,
      ST_WAIT,
      ST_COLL,
      ST_WRITE
   } seq_state_t;

endpackage

// File: rtl/lbm_cell_counter.sv
// Wrapping lattice cell counter 0..N-1 with synchronous clear and increment.
module lbm_cell_counter #(
   parameter int N      = 2048,
   parameter int ADDR_W = 11
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_clear,
   input  logic              i_inc,
   output logic [ADDR_W-1:0] o_count,
   output logic              o_last
);

   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N - 1);

   logic [ADDR_W-1:0] r_count;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_count <= '0;
      end else if (i_clear) begin
         r_count <= '0;
      end else if (i_inc) begin
         r_count <= o_last ? '0 : r_count + 1'b1;
      end
   end

   assign o_count = r_count;
   assign o_last  = (r_count == LAST_IDX);

endmodule

// File: rtl/lbm_collide_sequencer.sv
// Frame sequencer: read cell populations, drive the collider, write results back.
// Optional mass accumulator enabled by defining LBM_MASS_CHECK_EN.
module lbm_collide_sequencer
   import lbm_pkg::*;
#(
   parameter int NX      = 64,
   parameter int NY      = 32,
   parameter int ADDR_W  = 11,
   parameter int RD_LAT  = 1,
   parameter int COL_LAT = 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic [DW-1:0]       omega_in,
   output logic                busy,
   output logic                done,
   output logic [ADDR_W-1:0]   cell_idx,
   output logic                mem_rd_en,
   output logic [ADDR_W-1:0]   mem_rd_addr,
   input  logic [Q*DW-1:0]     mem_rd_data,
   output logic                mem_wr_en,
   input  logic                mem_wr_ready,
   output logic [ADDR_W-1:0]   mem_wr_addr,
   output logic [Q*DW-1:0]     mem_wr_data,
   output logic [DW-1:0]       col_omega,
   output logic [Q*DW-1:0]     col_f_in,
   input  logic [Q*DW-1:0]     col_f_out
`ifdef LBM_MASS_CHECK_EN
   ,
   input  logic [DW-1:0]       col_rho,
   output logic signed [31:0]  mass_sum
`endif
);

   localparam int         NCELL    = NX * NY;
   localparam logic [7:0] RD_LAST  = 8'(RD_LAT - 1);
   localparam logic [7:0] COL_LAST = 8'(COL_LAT - 1);

   seq_state_t        r_state;
   seq_state_t        w_next;
   logic [7:0]        r_lat;
   logic              r_busy;
   logic              r_done;
   logic              r_rd_en;
   logic              r_wr_en;
   logic [DW-1:0]     r_omega;
   logic [Q*DW-1:0]   r_f_in;
   logic [Q*DW-1:0]   r_wr_data;
   logic [ADDR_W-1:0] w_cell_idx;
   logic              w_last;
   logic              w_start_acc;
   logic              w_wr_fire;
   logic              w_rd_capture;
   logic              w_col_capture;

   assign w_start_acc   = (r_state == ST_IDLE) && start;
   assign w_wr_fire     = (r_state == ST_WRITE) && mem_wr_ready;
   assign w_rd_capture  = (r_state == ST_WAIT) && (r_lat == RD_LAST);
   assign w_col_capture = (r_state == ST_COLL) && (r_lat == COL_LAST);

   lbm_cell_counter #(
      .N      (NCELL),
      .ADDR_W (ADDR_W)
   ) u_cell_counter (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .i_clear (w_start_acc),
      .i_inc   (w_wr_fire),
      .o_count (w_cell_idx),
      .o_last  (w_last)
   );

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:  if (start) w_next = ST_READ;
         ST_READ:  w_next = ST_WAIT;
         ST_WAIT:  if (r_lat == RD_LAST) w_next = ST_COLL;
         ST_COLL:  if (r_lat == COL_LAST) w_next = ST_WRITE;
         ST_WRITE: if (mem_wr_ready) w_next = w_last ? ST_IDLE : ST_READ;
         default:  w_next = ST_IDLE;
      endcase
   end

   // Strobes are registered from the next state so they coincide with the state itself.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_lat   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_rd_en <= 1'b0;
         r_wr_en <= 1'b0;
      end else begin
         r_state <= w_next;
         r_lat   <= (w_next != r_state) ? 8'd0 : r_lat + 8'd1;
         r_busy  <= (w_next != ST_IDLE);
         r_done  <= w_wr_fire && w_last;
         r_rd_en <= (w_next == ST_READ);
         r_wr_en <= (w_next == ST_WRITE);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_omega   <= '0;
         r_f_in    <= '0;
         r_wr_data <= '0;
      end else begin
         if (w_start_acc)   r_omega   <= omega_in;
         if (w_rd_capture)  r_f_in    <= mem_rd_data;
         if (w_col_capture) r_wr_data <= col_f_out;
      end
   end

`ifdef LBM_MASS_CHECK_EN
   logic signed [31:0] r_mass;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mass <= '0;
      end else if (w_start_acc) begin
         r_mass <= '0;
      end else if (w_col_capture) begin
         r_mass <= r_mass + {{16{col_rho[DW-1]}}, col_rho};
      end
   end

   assign mass_sum = r_mass;
`endif

   assign busy        = r_busy;
   assign done        = r_done;
   assign cell_idx    = w_cell_idx;
   assign mem_rd_en   = r_rd_en;
   assign mem_rd_addr = w_cell_idx;
   assign mem_wr_en   = r_wr_en;
   assign mem_wr_addr = w_cell_idx;
   assign mem_wr_data = r_wr_data;
   assign col_omega   = r_omega;
   assign col_f_in    = r_f_in;

endmodule

// File: tb/tb_lbm_collide_sequencer.sv
// Self-checking bench for lbm_collide_sequencer on a 4x2 lattice with a memory and collider model.
module tb_lbm_collide_sequencer;

   localparam int NX  = 4;
   localparam int NY  = 2;
   localparam int AW  = 3;
   localparam int N   = NX * NY;
   localparam int CPC = 4;
   localparam int FW  = 144;

   logic          clk;
   logic          rst_n;
   logic          start;
   logic [15:0]   omega_in;
   logic          busy;
   logic          done;
   logic [AW-1:0] cell_idx;
   logic          mem_rd_en;
   logic [AW-1:0] mem_rd_addr;
   logic [FW-1:0] mem_rd_data;
   logic          mem_wr_en;
   logic          mem_wr_ready;
   logic [AW-1:0] mem_wr_addr;
   logic [FW-1:0] mem_wr_data;
   logic [15:0]   col_omega;
   logic [FW-1:0] col_f_in;
   logic [FW-1:0] col_f_out;
`ifdef LBM_MASS_CHECK_EN
   logic [15:0]        col_rho;
   logic signed [31:0] mass_sum;
`endif

   lbm_collide_sequencer #(
      .NX(NX), .NY(NY), .ADDR_W(AW), .RD_LAT(1), .COL_LAT(1)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .omega_in     (omega_in),
      .busy         (busy),
      .done         (done),
      .cell_idx     (cell_idx),
      .mem_rd_en    (mem_rd_en),
      .mem_rd_addr  (mem_rd_addr),
      .mem_rd_data  (mem_rd_data),
      .mem_wr_en    (mem_wr_en),
      .mem_wr_ready (mem_wr_ready),
      .mem_wr_addr  (mem_wr_addr),
      .mem_wr_data  (mem_wr_data),
      .col_omega    (col_omega),
      .col_f_in     (col_f_in),
      .col_f_out    (col_f_out)
`ifdef LBM_MASS_CHECK_EN
      ,
      .col_rho      (col_rho),
      .mass_sum     (mass_sum)
`endif
   );

   int            n_chk;
   int            n_fail;
   logic [FW-1:0] mem     [N];
   logic [FW-1:0] exp_mem [N];
   logic [FW-1:0] rd_q;
   logic [AW-1:0] wr_log [$];
   logic          mode;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory model: one-cycle read latency, write on handshake.
   always @(posedge clk) begin
      if (mem_rd_en) rd_q <= mem[mem_rd_addr];
      if (mem_wr_en && mem_wr_ready) begin
         mem[mem_wr_addr] = mem_wr_data;
         wr_log.push_back(mem_wr_addr);
      end
   end
   assign mem_rd_data = rd_q;

   // Collider model: identity, or +1 on every lane.
   always_comb begin
      col_f_out = '0;
      for (int k = 0; k < 9; k++)
         col_f_out[k*16 +: 16] = col_f_in[k*16 +: 16] + {15'd0, mode};
   end

   function automatic logic [FW-1:0] ref_coll(input logic [FW-1:0] w, input logic inc);
      logic [FW-1:0] r;
      r = '0;
      for (int k = 0; k < 9; k++) r[k*16 +: 16] = w[k*16 +: 16] + (inc ? 16'd1 : 16'd0);
      return r;
   endfunction

   task automatic chk(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, " busy"},      FW'(busy), '0);
      chk({tag, " done"},      FW'(done), '0);
      chk({tag, " rd_en"},     FW'(mem_rd_en), '0);
      chk({tag, " wr_en"},     FW'(mem_wr_en), '0);
      chk({tag, " cell_idx"},  FW'(cell_idx), '0);
      chk({tag, " rd_addr"},   FW'(mem_rd_addr), '0);
      chk({tag, " wr_addr"},   FW'(mem_wr_addr), '0);
      chk({tag, " col_omega"}, FW'(col_omega), '0);
      chk({tag, " col_f_in"},  col_f_in, '0);
      chk({tag, " wr_data"},   mem_wr_data, '0);
   endtask

   // Runs one frame. abort_cell >= 0 asserts reset once cell_idx reaches it and returns early.
   task automatic run_frame(input logic [15:0] om, input logic inc, input int om_change_lat,
                            input int restart_lat, input int stall_cell, input int stall_len,
                            input int abort_cell);
      int            lat;
      int            busy_cnt;
      int            done_lat;
      int            stall_left;
      bit            in_stall;
      bit            aborted;
      logic [FW-1:0] snap;
      for (int c = 0; c < N; c++) exp_mem[c] = ref_coll(mem[c], inc);
      wr_log.delete();
      mode = inc;
      @(negedge clk);
      omega_in = om;
      start    = 1'b1;
      @(negedge clk);
      start      = 1'b0;
      lat        = 0;
      busy_cnt   = 0;
      done_lat   = -1;
      stall_left = stall_len;
      in_stall   = 1'b0;
      aborted    = 1'b0;
      snap       = '0;
      while (lat < 200 && done_lat < 0) begin
         if (busy) busy_cnt++;
         if (done) done_lat = lat;
         chk("col_omega held", FW'(col_omega), FW'(om));
         start = (lat == restart_lat);
         if (lat == restart_lat) omega_in = 16'h1111;
         if (lat == om_change_lat) omega_in = 16'h1000;
         if (!in_stall && stall_left > 0 && mem_wr_en && mem_wr_addr == stall_cell[AW-1:0]) begin
            in_stall     = 1'b1;
            snap         = mem_wr_data;
            mem_wr_ready = 1'b0;
            stall_left--;
         end else if (in_stall) begin
            chk("stall wr_en", FW'(mem_wr_en), FW'(1));
            chk("stall wr_addr", FW'(mem_wr_addr), FW'(stall_cell));
            chk("stall wr_data", mem_wr_data, snap);
            if (stall_left > 0) begin
               mem_wr_ready = 1'b0;
               stall_left--;
            end else begin
               mem_wr_ready = 1'b1;
               in_stall     = 1'b0;
            end
         end
         if (abort_cell >= 0 && busy && cell_idx == abort_cell[AW-1:0]) begin
            rst_n   = 1'b0;
            aborted = 1'b1;
            break;
         end
         @(negedge clk);
         lat++;
      end
      start = 1'b0;
      if (aborted) begin
         #1;
         chk_all_zero("abort reset");
         repeat (3) @(negedge clk);
         chk_all_zero("abort held");
         chk("abort write count", FW'(wr_log.size()), FW'(abort_cell));
         for (int i = 0; i < wr_log.size(); i++) chk("abort write order", FW'(wr_log[i]), FW'(i));
         for (int c = 0; c < N; c++)
            chk("abort memory", mem[c], (c < abort_cell) ? exp_mem[c] : ref_coll(exp_mem[c], 1'b0) ^ (inc ? ref_coll(mem[c], 1'b0) ^ exp_mem[c] : '0));
      end else begin
         chk("done latency", FW'(done_lat), FW'(N * CPC + stall_len));
         chk("busy cycles", FW'(busy_cnt), FW'(N * CPC + stall_len));
`ifdef LBM_MASS_CHECK_EN
         chk("mass_sum at done", FW'(mass_sum), FW'(32'h0001_0000));
`endif
         @(negedge clk);
         chk("done one cycle", FW'(done), '0);
         chk("idle busy", FW'(busy), '0);
         chk("write count", FW'(wr_log.size()), FW'(N));
         for (int i = 0; i < wr_log.size(); i++) chk("write order", FW'(wr_log[i]), FW'(i));
         for (int c = 0; c < N; c++) chk("memory after frame", mem[c], exp_mem[c]);
      end
   endtask

   initial begin
      logic [FW-1:0] orig [N];
      n_chk        = 0;
      n_fail       = 0;
      rst_n        = 1'b1;
      start        = 1'b0;
      omega_in     = '0;
      mem_wr_ready = 1'b1;
      mode         = 1'b0;
      rd_q         = '0;
`ifdef LBM_MASS_CHECK_EN
      col_rho      = 16'h2000;
`endif
      for (int c = 0; c < N; c++)
         for (int k = 0; k < 9; k++) mem[c][k*16 +: 16] = 16'(c * 16 + k);

      #2 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      chk_all_zero("reset");
      rst_n = 1'b1;

      // Identity collider, omega changed mid-frame.
      run_frame(16'h2000, 1'b0, 12, -1, -1, 0, -1);
      // +1 collider with a 5-cycle write stall on cell 3.
      run_frame(16'h1800, 1'b1, -1, -1, 3, 5, -1);

      // Random data, a second start pulsed while busy.
      for (int c = 0; c < N; c++)
         for (int k = 0; k < 9; k++) mem[c][k*16 +: 16] = 16'($urandom);
      run_frame(16'($urandom), 1'b1, -1, 10, -1, 0, -1);

      // Random data, reset at cell 5: cells 5..7 must keep their old contents.
      for (int c = 0; c < N; c++) begin
         for (int k = 0; k < 9; k++) mem[c][k*16 +: 16] = 16'($urandom);
         orig[c] = mem[c];
      end
      run_frame(16'h2000, 1'b1, -1, -1, -1, 0, 5);
      for (int c = 5; c < N; c++) chk("untouched after abort", mem[c], orig[c]);
      @(negedge clk);
      rst_n = 1'b1;

      // Fresh frame after the abort restarts at cell 0.
      run_frame(16'h0800, 1'b0, -1, -1, -1, 0, -1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
